// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the cache-to-memory port arbiter.
// Round-robin search is used only when MEM_ARB_RR_EN is defined.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_e;

  localparam int ADDR_W_DEF = 28;
  localparam int LINE_W_DEF = 128;
  localparam int MAX_CH     = 8;

  // First requester after 'last', wrapping modulo n.
  function automatic logic [2:0] rr_pick(
    input logic [MAX_CH-1:0] req,
    input logic [2:0]        last,
    input int                n
  );
    logic [2:0] idx;
    logic       found;
    int         c;
    idx   = last;
    found = 1'b0;
    for (int i = 1; i <= MAX_CH; i++) begin
      c = (int'(last) + i) % n;
      if (i <= n && !found && req[c]) begin
        idx   = 3'(c);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  function automatic logic [2:0] fp_pick(
    input logic [MAX_CH-1:0] req
  );
    logic [2:0] idx;
    idx = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache miss ports plus the single memory port seen by the arbiter.
// master: arbiter side; slave: caches and memory side.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
);
  logic [NUM_CH-1:0]        ch_read;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*LINE_W-1:0] ch_wdata;
  logic [LINE_W-1:0]        ch_rdata;
  logic [NUM_CH-1:0]        ch_ready;
  logic                     mem_read;
  logic                     mem_write;
  logic [ADDR_W-1:0]        mem_addr;
  logic [LINE_W-1:0]        mem_wdata;
  logic [LINE_W-1:0]        mem_rdata;
  logic                     mem_ready;

  modport master (
    input  ch_read, ch_write, ch_addr, ch_wdata,
    input  mem_rdata, mem_ready,
    output ch_rdata, ch_ready,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    output ch_read, ch_write, ch_addr, ch_wdata,
    output mem_rdata, mem_ready,
    input  ch_rdata, ch_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_rsp_pipe.sv
// Delay line of {valid, data}, DEPTH 0..3, asynchronously cleared.
// DEPTH 0 is a plain wire.
module mem_rsp_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign out_valid = in_valid;
      assign out_data  = in_data;
    end else begin : g_reg
      logic [DEPTH-1:0] v;
      logic [W-1:0]     d [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v <= '0;
          for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else begin
          v[0] <= in_valid;
          d[0] <= in_data;
          for (int i = 1; i < DEPTH; i++) begin
            v[i] <= v[i-1];
            d[i] <= d[i-1];
          end
        end
      end

      assign out_valid = v[DEPTH-1];
      assign out_data  = d[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Shared line-memory arbiter for NUM_CH cache miss ports.
// MEM_ARB_RR_EN selects round-robin; otherwise lowest index wins.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LINE_W     = LINE_W_DEF,
  parameter int RSP_STAGES = 1
) (
  input logic           clk,
  input logic           proc_reset,
  mem_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_CH);

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic [IDX_W-1:0]  g;
  logic [IDX_W-1:0]  g_nxt;
  logic [IDX_W-1:0]  pick;
  logic [NUM_CH-1:0] req;
  logic              rsp_valid;
  logic [LINE_W-1:0] rsp_data;

  assign req = bus.ch_read | bus.ch_write;

`ifdef MEM_ARB_RR_EN
  logic [IDX_W-1:0] last;

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      last <= IDX_W'(NUM_CH - 1);
    end else if (state == IDLE && |req) begin
      last <= pick;
    end
  end

  assign pick = IDX_W'(rr_pick(8'(req), 3'(last), NUM_CH));
`else
  assign pick = IDX_W'(fp_pick(8'(req)));
`endif

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state <= IDLE;
      g     <= '0;
    end else begin
      state <= state_nxt;
      g     <= g_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    g_nxt         = g;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.ch_ready  = '0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          g_nxt     = pick;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        bus.mem_addr  = bus.ch_addr[int'(g)*ADDR_W +: ADDR_W];
        bus.mem_wdata = bus.ch_wdata[int'(g)*LINE_W +: LINE_W];
        bus.mem_write = bus.ch_write[g];
        bus.mem_read  = bus.ch_read[g] & ~bus.ch_write[g];
        if (RSP_STAGES == 0) bus.ch_ready[g] = rsp_valid;
        if (bus.mem_ready) begin
          state_nxt = (RSP_STAGES == 0) ? IDLE : RESP;
        end
      end
      RESP: begin
        // Memory port stays quiet here so a held request cannot restart it.
        if (rsp_valid) begin
          bus.ch_ready[g] = 1'b1;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  mem_rsp_pipe #(
    .DEPTH (RSP_STAGES),
    .W     (LINE_W)
  ) u_rsp (
    .clk       (clk),
    .rst       (proc_reset),
    .in_valid  (bus.mem_ready),
    .in_data   (bus.mem_rdata),
    .out_valid (rsp_valid),
    .out_data  (rsp_data)
  );

  assign bus.ch_rdata = rsp_data;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised shared-memory port arbiter between NUM_CH cache miss ports (I-cache, D-cache, and later additions) and one slow line-wide memory. It grants one channel at a time and forwards that channel's read or write. It returns the memory response through a configurable-depth retiming pipeline, which generalises the fixed one-stage mem_rdata/mem_ready register at the chip top. It sits between the cache instances and the external memory pins.

## Interface
Parameters:
- NUM_CH, 2, number of cache channels (2..8)
- ADDR_W, 28, line address width (byte address bits [31:4])
- LINE_W, 128, line data width
- RSP_STAGES, 1, response register stages between memory and caches (0..3)

Ports:
- clk  in  1  clock; all state on rising edge
- proc_reset  in  1  asynchronous, active-high reset
- ch_read  in  NUM_CH  per-channel read request, held until ch_ready
- ch_write  in  NUM_CH  per-channel write request, held until ch_ready
- ch_addr  in  NUM_CH*ADDR_W  per-channel line address, channel i at [i*ADDR_W +: ADDR_W]
- ch_wdata  in  NUM_CH*LINE_W  per-channel write line
- ch_rdata  out  LINE_W  read line, broadcast to all channels
- ch_ready  out  NUM_CH  one-cycle completion pulse, one-hot on the granted channel
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_addr  out  ADDR_W  memory line address
- mem_wdata  out  LINE_W  memory write line
- mem_rdata  in  LINE_W  memory read line
- mem_ready  in  1  memory completion pulse

## Operation
- FSM states: IDLE, BUSY, RESP. Additional registers: grant index g, round-robin pointer last, response pipeline.
- IDLE:
  - If any channel has ch_read|ch_write, latch the winner into g and go to BUSY.
  - Otherwise stay in IDLE.
  - mem_read, mem_write, mem_addr and mem_wdata are 0.
- BUSY:
  - mem_addr and mem_wdata are muxed live from channel g.
  - mem_write = ch_write[g].
  - mem_read = ch_read[g] & ~ch_write[g]; write wins if both are asserted.
  - On mem_ready: go to RESP if RSP_STAGES>0; go to IDLE if RSP_STAGES==0.
- RESP:
  - All mem_* outputs are 0, so a still-held cache request cannot restart memory.
  - Wait until the pipeline output's ready bit is 1, then go to IDLE.
- Response pipeline:
  - RSP_STAGES registers of {mem_ready, mem_rdata}, shifting every cycle.
  - ch_rdata is the pipeline output data, or mem_rdata directly when RSP_STAGES==0.
- ch_ready[g] is the pipeline output ready bit qualified by state (BUSY when RSP_STAGES==0, RESP otherwise). All other ch_ready bits are 0.
- mem_ready arriving in IDLE or RESP is not qualified, so it never produces a ch_ready pulse.
- Grant is held until completion. Channel requests are never preempted.
- A channel that drops its request mid-BUSY is a protocol violation. The arbiter keeps the grant and completes on mem_ready.

## Timing
- Reset (asynchronous, any state): state=IDLE, g=0, last=NUM_CH-1, pipeline cleared. All outputs are 0 during reset and in the first cycle after it.
- Arbitration latency is 1 cycle. A request first visible in cycle t gives mem_read/mem_write high in cycle t+1.
- mem_ready in cycle m gives:
  - mem_* low from cycle m+1;
  - ch_ready[g] in cycle m+RSP_STAGES;
  - IDLE in cycle m+RSP_STAGES+1.
- The cache drops its request at the edge ending its ch_ready cycle, so the IDLE cycle sees only fresh requests.
- Back-to-back transactions have at least 1 IDLE cycle between completion pulse and next memory request.
- Reset mid-transaction aborts silently. No ch_ready is issued for the aborted transaction.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. The search starts at (last+1) mod NUM_CH, and last is updated to g on every grant.
- MEM_ARB_RR_EN undefined: fixed priority, lowest index wins. The last register is not built.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE/BUSY/RESP);
  - the default ADDR_W/LINE_W constants;
  - a function for the round-robin next-index search.
- Sub-module mem_rsp_pipe is a parametrised delay line of {valid, data} with depth 0..3 and asynchronous clear. It is instantiated once.

## Test plan
1. NUM_CH=2, RSP_STAGES=1:
   - Stimulus: ch_read[1]=1, addr 28'h0000040; memory returns 128'hA5..A5 after 4 cycles.
   - Response: mem_read=1, mem_addr=28'h0000040 for the BUSY cycles; ch_ready=2'b10 one cycle after mem_ready; ch_rdata=128'hA5..A5.
2. Write:
   - Stimulus: ch_write[0]=1, addr 28'h0000100, wdata 128'h1234; mem_ready after 3 cycles.
   - Response: mem_write=1, mem_wdata=128'h1234; mem_read=0 throughout; ch_ready=2'b01 once.
3. Both channels request every cycle with MEM_ARB_RR_EN:
   - Response: grants alternate 0,1,0,1.
   - Without the macro, channel 0 is granted every time.
4. RSP_STAGES=0 and RSP_STAGES=3:
   - ch_ready is coincident with mem_ready for 0 and 3 cycles later for 3.
   - mem_read is low during RESP while the cache holds ch_read.
5. Stray inputs:
   - Stimulus: mem_ready pulsed in IDLE.
   - Response: no ch_ready.
   - Stimulus: proc_reset asserted in BUSY.
   - Response: mem_read drops immediately; no ch_ready; next request is granted normally.
